// File: rtl/alu_req_arbiter_if.sv
// rtl/alu_req_arbiter_if.sv - request, response and datapath signal bundle for alu_req_arbiter
interface alu_req_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [2:0]       req0_ctr;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [2:0]       req1_ctr;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_err;
    logic [WIDTH-1:0] alu_src1;
    logic [WIDTH-1:0] alu_src2;
    logic [2:0]       alu_ctr;
    logic [WIDTH-1:0] alu_result;
    logic             mod_start;
    logic             mod_done;
    logic [WIDTH-1:0] mod_result;
    logic             busy;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_ctr, req0_a, req0_b,
        input  req1_valid, req1_ctr, req1_a, req1_b,
        input  rsp_ready, alu_result, mod_done, mod_result,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_err,
        output alu_src1, alu_src2, alu_ctr, mod_start, busy
    );

    // Requester, consumer and datapath side
    modport master (
        output req0_valid, req0_ctr, req0_a, req0_b,
        output req1_valid, req1_ctr, req1_a, req1_b,
        output rsp_ready, alu_result, mod_done, mod_result,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_err,
        input  alu_src1, alu_src2, alu_ctr, mod_start, busy
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// rtl/alu_req_arbiter.sv - round-robin ALU/mod request arbiter, optional ALU_ARB_PERF_CNT_EN counters
module alu_req_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    alu_req_arbiter_if.slave  bus
`ifdef ALU_ARB_PERF_CNT_EN
    ,
    output logic [15:0]       op_count,
    output logic [7:0]        timeout_count
`endif
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [2:0]    CTR_MOD  = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        ALU,
        MOD_START,
        MOD_WAIT,
        RESP
    } state_t;

    state_t           state;
    logic             last_grant;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_err_q;
    logic [WIDTH-1:0] src1_q;
    logic [WIDTH-1:0] src2_q;
    logic [2:0]       ctr_q;
    logic             mod_start_q;
    logic [CW-1:0]    wait_cnt;

    logic             grant_any;
    logic             grant_id;
    logic [2:0]       sel_ctr;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             timeout_hit;

    // Round-robin pick: a tie goes to whoever was not granted last
    always_comb begin
        grant_any = bus.req0_valid | bus.req1_valid;
        grant_id  = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = bus.req1_valid;
        end
        sel_ctr = grant_id ? bus.req1_ctr : bus.req0_ctr;
        sel_a   = grant_id ? bus.req1_a   : bus.req0_a;
        sel_b   = grant_id ? bus.req1_b   : bus.req0_b;
    end

    assign timeout_hit    = (state == MOD_WAIT) && !bus.mod_done && (wait_cnt == CNT_LAST);

    assign bus.req0_ready = (state == IDLE) && grant_any && !grant_id;
    assign bus.req1_ready = (state == IDLE) && grant_any &&  grant_id;
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.alu_src1   = src1_q;
    assign bus.alu_src2   = src2_q;
    assign bus.alu_ctr    = ctr_q;
    assign bus.mod_start  = mod_start_q;
    assign bus.busy       = (state != IDLE);

    // Operation sequencer: grant, execute or launch mod, then hold the response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
            src1_q       <= '0;
            src2_q       <= '0;
            ctr_q        <= 3'b000;
            mod_start_q  <= 1'b0;
            wait_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        last_grant <= grant_id;
                        rsp_id_q   <= grant_id;
                        src1_q     <= sel_a;
                        src2_q     <= sel_b;
                        ctr_q      <= sel_ctr;
                        if (sel_ctr == CTR_MOD && sel_b == '0) begin
                            // Divide-by-zero is answered without touching the mod unit
                            rsp_result_q <= '0;
                            rsp_err_q    <= 1'b1;
                            state        <= RESP;
                        end else if (sel_ctr == CTR_MOD) begin
                            mod_start_q <= 1'b1;
                            state       <= MOD_START;
                        end else begin
                            state <= ALU;
                        end
                    end
                end
                ALU: begin
                    rsp_result_q <= bus.alu_result;
                    rsp_err_q    <= 1'b0;
                    state        <= RESP;
                end
                MOD_START: begin
                    mod_start_q <= 1'b0;
                    wait_cnt    <= '0;
                    state       <= MOD_WAIT;
                end
                MOD_WAIT: begin
                    if (bus.mod_done) begin
                        rsp_result_q <= bus.mod_result;
                        rsp_err_q    <= 1'b0;
                        state        <= RESP;
                    end else if (wait_cnt == CNT_LAST) begin
                        rsp_result_q <= '0;
                        rsp_err_q    <= 1'b1;
                        state        <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ARB_PERF_CNT_EN
    // Saturating counts of completed responses and mod timeouts
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_count      <= 16'h0000;
            timeout_count <= 8'h00;
        end else begin
            if (state == RESP && bus.rsp_ready && op_count != 16'hFFFF) begin
                op_count <= op_count + 16'h0001;
            end
            if (timeout_hit && timeout_count != 8'hFF) begin
                timeout_count <= timeout_count + 8'h01;
            end
        end
    end
`endif
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb/tb_alu_req_arbiter.sv - directed self-checking bench for alu_req_arbiter
module tb_alu_req_arbiter;
    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 64;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    alu_req_arbiter_if #(.WIDTH(WIDTH)) bus();

`ifdef ALU_ARB_PERF_CNT_EN
    logic [15:0] op_count;
    logic [7:0]  timeout_count;
`endif

    alu_req_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef ALU_ARB_PERF_CNT_EN
        ,
        .op_count      (op_count),
        .timeout_count (timeout_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference single-cycle ALU driven from the registered operands
    always_comb begin
        case (bus.alu_ctr)
            3'b000:  bus.alu_result = bus.alu_src1 & bus.alu_src2;
            3'b001:  bus.alu_result = bus.alu_src1 | bus.alu_src2;
            3'b010:  bus.alu_result = bus.alu_src1 + bus.alu_src2;
            3'b110:  bus.alu_result = bus.alu_src1 - bus.alu_src2;
            default: bus.alu_result = bus.alu_src1 ^ bus.alu_src2;
        endcase
    end

    task automatic test_reset();
        bus.req0_valid = 1'b0; bus.req0_ctr = 3'b000; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_ctr = 3'b000; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp_ready  = 1'b0; bus.mod_done = 1'b0; bus.mod_result = '0;
        reset = 1'b0;
        @(negedge clk); #1;
        vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %0h expected 0", bus.rsp_valid); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0h expected 0", bus.busy); end
        vectors++; if (bus.mod_start !== 1'b0) begin miscompares++; $display("FAIL reset_mod_start: got %0h expected 0", bus.mod_start); end
        vectors++; if (bus.alu_src1 !== 32'h0) begin miscompares++; $display("FAIL reset_alu_src1: got %0h expected 0", bus.alu_src1); end
        vectors++; if (bus.rsp_result !== 32'h0) begin miscompares++; $display("FAIL reset_rsp_result: got %0h expected 0", bus.rsp_result); end
        vectors++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin miscompares++; $display("FAIL reset_ready: got %b expected 00", {bus.req1_ready, bus.req0_ready}); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_back_to_back();
        bit found;
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_ctr = 3'b010; bus.req0_a = 32'd1;  bus.req0_b = 32'd2;
        bus.req1_valid = 1'b1; bus.req1_ctr = 3'b110; bus.req1_a = 32'd10; bus.req1_b = 32'd3;
        bus.rsp_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            found = 1'b0;
            for (int c = 0; c < 8 && !found; c++) begin
                #1;
                if (bus.req0_ready || bus.req1_ready) found = 1'b1;
                else @(negedge clk);
            end
            vectors++; if (!found) begin miscompares++; $display("FAIL b2b_grant_wait op %0d: got no ready expected a grant", i); end
            vectors++; if ({bus.req1_ready, bus.req0_ready} !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL b2b_grant op %0d: got %b expected %b", i, {bus.req1_ready, bus.req0_ready}, (i % 2 == 1) ? 2'b10 : 2'b01); end
            found = 1'b0;
            @(negedge clk);
            for (int c = 0; c < 8 && !found; c++) begin
                #1;
                if (bus.rsp_valid) found = 1'b1;
                else @(negedge clk);
            end
            vectors++; if (!found) begin miscompares++; $display("FAIL b2b_rsp_wait op %0d: got no rsp_valid expected one", i); end
            vectors++; if (bus.rsp_id !== ((i % 2 == 1) ? 1'b1 : 1'b0)) begin miscompares++; $display("FAIL b2b_rsp_id op %0d: got %0h expected %0d", i, bus.rsp_id, i % 2); end
            vectors++; if (bus.rsp_result !== ((i % 2 == 1) ? 32'd7 : 32'd3)) begin miscompares++; $display("FAIL b2b_rsp_result op %0d: got %0d expected %0d", i, bus.rsp_result, (i % 2 == 1) ? 7 : 3); end
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic test_single_alu();
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_ctr = 3'b010; bus.req0_a = 32'd5; bus.req0_b = 32'd7;
        bus.rsp_ready  = 1'b1;
        #1;
        vectors++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin miscompares++; $display("FAIL alu_ready_c0: got %b expected 01", {bus.req1_ready, bus.req0_ready}); end
        @(negedge clk);
        bus.req0_valid = 1'b0;
        #1;
        vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL alu_rsp_valid_c1: got %0h expected 0", bus.rsp_valid); end
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL alu_busy_c1: got %0h expected 1", bus.busy); end
        vectors++; if ({bus.alu_ctr, bus.alu_src1, bus.alu_src2} !== {3'b010, 32'd5, 32'd7}) begin miscompares++; $display("FAIL alu_operands_c1: got %0h/%0d/%0d expected 2/5/7", bus.alu_ctr, bus.alu_src1, bus.alu_src2); end
        @(negedge clk); #1;
        vectors++; if (bus.rsp_valid !== 1'b1) begin miscompares++; $display("FAIL alu_rsp_valid_c2: got %0h expected 1", bus.rsp_valid); end
        vectors++; if (bus.rsp_id !== 1'b0) begin miscompares++; $display("FAIL alu_rsp_id: got %0h expected 0", bus.rsp_id); end
        vectors++; if (bus.rsp_result !== 32'd12) begin miscompares++; $display("FAIL alu_rsp_result: got %0d expected 12", bus.rsp_result); end
        vectors++; if (bus.rsp_err !== 1'b0) begin miscompares++; $display("FAIL alu_rsp_err: got %0h expected 0", bus.rsp_err); end
        @(negedge clk); #1;
        vectors++; if ({bus.rsp_valid, bus.busy} !== 2'b00) begin miscompares++; $display("FAIL alu_after_handshake: got %b expected 00", {bus.rsp_valid, bus.busy}); end
    endtask

    task automatic test_mod();
        int pulses;
        int early;
        @(negedge clk);
        bus.req1_valid = 1'b1; bus.req1_ctr = 3'b111; bus.req1_a = 32'd17; bus.req1_b = 32'd5;
        bus.rsp_ready  = 1'b1;
        #1;
        vectors++; if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin miscompares++; $display("FAIL mod_ready_c0: got %b expected 10", {bus.req1_ready, bus.req0_ready}); end
        @(negedge clk);
        bus.req1_valid = 1'b0;
        #1;
        vectors++; if (bus.mod_start !== 1'b1) begin miscompares++; $display("FAIL mod_start_c1: got %0h expected 1", bus.mod_start); end
        vectors++; if ({bus.alu_ctr, bus.alu_src1, bus.alu_src2} !== {3'b111, 32'd17, 32'd5}) begin miscompares++; $display("FAIL mod_operands_c1: got %0h/%0d/%0d expected 7/17/5", bus.alu_ctr, bus.alu_src1, bus.alu_src2); end
        pulses = int'(bus.mod_start);
        early  = 0;
        for (int cyc = 2; cyc <= 11; cyc++) begin
            @(negedge clk);
            if (cyc == 11) begin
                bus.mod_done   = 1'b1;
                bus.mod_result = 32'd2;
            end
            #1;
            pulses += int'(bus.mod_start);
            early  += int'(bus.rsp_valid);
        end
        @(negedge clk);
        bus.mod_done = 1'b0;
        #1;
        vectors++; if (bus.rsp_valid !== 1'b1) begin miscompares++; $display("FAIL mod_rsp_valid: got %0h expected 1", bus.rsp_valid); end
        vectors++; if ({bus.rsp_id, bus.rsp_err} !== 2'b10) begin miscompares++; $display("FAIL mod_rsp_id_err: got %b expected 10", {bus.rsp_id, bus.rsp_err}); end
        vectors++; if (bus.rsp_result !== 32'd2) begin miscompares++; $display("FAIL mod_rsp_result: got %0d expected 2", bus.rsp_result); end
        vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL mod_start_pulses: got %0d expected 1", pulses); end
        vectors++; if (early !== 0) begin miscompares++; $display("FAIL mod_early_rsp: got %0d cycles expected 0", early); end
        @(negedge clk); #1;
        vectors++; if ({bus.rsp_valid, bus.busy} !== 2'b00) begin miscompares++; $display("FAIL mod_after_handshake: got %b expected 00", {bus.rsp_valid, bus.busy}); end
    endtask

    task automatic test_mod_zero();
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_ctr = 3'b111; bus.req0_a = 32'd9; bus.req0_b = 32'd0;
        bus.rsp_ready  = 1'b1;
        #1;
        vectors++; if (bus.req0_ready !== 1'b1) begin miscompares++; $display("FAIL modz_ready_c0: got %0h expected 1", bus.req0_ready); end
        @(negedge clk);
        bus.req0_valid = 1'b0;
        #1;
        vectors++; if (bus.rsp_valid !== 1'b1) begin miscompares++; $display("FAIL modz_rsp_valid_c1: got %0h expected 1", bus.rsp_valid); end
        vectors++; if ({bus.rsp_id, bus.rsp_err} !== 2'b01) begin miscompares++; $display("FAIL modz_rsp_id_err: got %b expected 01", {bus.rsp_id, bus.rsp_err}); end
        vectors++; if (bus.rsp_result !== 32'd0) begin miscompares++; $display("FAIL modz_rsp_result: got %0d expected 0", bus.rsp_result); end
        vectors++; if (bus.mod_start !== 1'b0) begin miscompares++; $display("FAIL modz_mod_start: got %0h expected 0", bus.mod_start); end
        @(negedge clk); #1;
        vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL modz_after_handshake: got %0h expected 0", bus.rsp_valid); end
    endtask

    task automatic test_timeout();
        int early;
        int spurious;
        @(negedge clk);
        bus.req1_valid = 1'b1; bus.req1_ctr = 3'b111; bus.req1_a = 32'd3; bus.req1_b = 32'd4;
        bus.rsp_ready  = 1'b1;
        #1;
        vectors++; if (bus.req1_ready !== 1'b1) begin miscompares++; $display("FAIL tmo_ready_c0: got %0h expected 1", bus.req1_ready); end
        @(negedge clk);
        bus.req1_valid = 1'b0;
        early = 0;
        // MOD_WAIT occupies cycles 2..65
        for (int cyc = 2; cyc <= 65; cyc++) begin
            @(negedge clk); #1;
            early += int'(bus.rsp_valid);
        end
        @(negedge clk); #1;
        vectors++; if (early !== 0) begin miscompares++; $display("FAIL tmo_early_rsp: got %0d cycles expected 0", early); end
        vectors++; if (bus.rsp_valid !== 1'b1) begin miscompares++; $display("FAIL tmo_rsp_valid_c66: got %0h expected 1", bus.rsp_valid); end
        vectors++; if ({bus.rsp_id, bus.rsp_err} !== 2'b11) begin miscompares++; $display("FAIL tmo_rsp_id_err: got %b expected 11", {bus.rsp_id, bus.rsp_err}); end
        vectors++; if (bus.rsp_result !== 32'd0) begin miscompares++; $display("FAIL tmo_rsp_result: got %0d expected 0", bus.rsp_result); end
        repeat (5) @(negedge clk);
        bus.mod_done   = 1'b1;
        bus.mod_result = 32'd99;
        spurious = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            spurious += int'(bus.rsp_valid | bus.busy | bus.mod_start);
            @(negedge clk);
            bus.mod_done = 1'b0;
        end
        vectors++; if (spurious !== 0) begin miscompares++; $display("FAIL tmo_spurious_done: got %0d active cycles expected 0", spurious); end
`ifdef ALU_ARB_PERF_CNT_EN
        vectors++; if (op_count !== 16'd8) begin miscompares++; $display("FAIL perf_op_count: got %0d expected 8", op_count); end
        vectors++; if (timeout_count !== 8'd1) begin miscompares++; $display("FAIL perf_timeout_count: got %0d expected 1", timeout_count); end
`endif
    endtask

    task automatic test_stall_reset();
        int unstable;
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_ctr = 3'b000; bus.req0_a = 32'hF0; bus.req0_b = 32'h3C;
        bus.rsp_ready  = 1'b0;
        #1;
        vectors++; if (bus.req0_ready !== 1'b1) begin miscompares++; $display("FAIL stall_ready_c0: got %0h expected 1", bus.req0_ready); end
        @(negedge clk);
        bus.req0_valid = 1'b0;
        @(negedge clk); #1;
        vectors++; if ({bus.rsp_valid, bus.rsp_result} !== {1'b1, 32'h30}) begin miscompares++; $display("FAIL stall_rsp_c2: got %0h/%0h expected 1/30", bus.rsp_valid, bus.rsp_result); end
        unstable = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            if (!(bus.rsp_valid === 1'b1 && bus.rsp_id === 1'b0 && bus.rsp_result === 32'h30 &&
                  bus.rsp_err === 1'b0 && bus.alu_src1 === 32'hF0 && bus.busy === 1'b1))
                unstable++;
        end
        vectors++; if (unstable !== 0) begin miscompares++; $display("FAIL stall_stable: got %0d changed cycles expected 0", unstable); end
        reset = 1'b0;
        #1;
        vectors++; if ({bus.rsp_valid, bus.busy, bus.mod_start, bus.rsp_err, bus.rsp_id} !== 5'b00000) begin miscompares++; $display("FAIL rst_mid_flags: got %b expected 00000", {bus.rsp_valid, bus.busy, bus.mod_start, bus.rsp_err, bus.rsp_id}); end
        vectors++; if ({bus.rsp_result, bus.alu_src1, bus.alu_src2, bus.alu_ctr} !== '0) begin miscompares++; $display("FAIL rst_mid_data: got %0h/%0h/%0h/%0h expected 0", bus.rsp_result, bus.alu_src1, bus.alu_src2, bus.alu_ctr); end
`ifdef ALU_ARB_PERF_CNT_EN
        vectors++; if ({op_count, timeout_count} !== 24'h0) begin miscompares++; $display("FAIL rst_mid_perf: got %0h/%0h expected 0", op_count, timeout_count); end
`endif
        @(negedge clk);
        reset = 1'b1;
        bus.rsp_ready  = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_ctr = 3'b001; bus.req0_a = 32'h1; bus.req0_b = 32'h2;
        bus.req1_valid = 1'b1; bus.req1_ctr = 3'b001; bus.req1_a = 32'h4; bus.req1_b = 32'h8;
        #1;
        vectors++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin miscompares++; $display("FAIL rst_tie_grant: got %b expected 01", {bus.req1_ready, bus.req0_ready}); end
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk); #1;
        vectors++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result} !== {1'b1, 1'b0, 32'h3}) begin miscompares++; $display("FAIL rst_next_rsp: got %0h/%0h/%0h expected 1/0/3", bus.rsp_valid, bus.rsp_id, bus.rsp_result); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_single_alu();
        test_mod();
        test_mod_zero();
        test_timeout();
        test_stall_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end
endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares one ALU datapath between two requesters. The datapath is a single-cycle combinational ALU plus a multi-cycle mod unit with a start/done handshake.
- Arbitrates between the requesters round-robin and sequences each operation:
  - single-cycle ops sample the ALU result directly;
  - alu_ctr 3'b111 (mod) launches the mod unit, waits for done, and enforces a timeout.
- Returns each result to the granted requester through a valid/ready response channel.
- Sits between the CPU-side issue logic and the ALU/mod datapath.

Parameters:
- WIDTH, 32, operand and result width.
- TIMEOUT, 64, maximum cycles spent in MOD_WAIT before the operation is aborted; must be >= 2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_ctr  in  3  requester 0 alu_ctr code.
- req0_a  in  WIDTH  requester 0 operand 1.
- req0_b  in  WIDTH  requester 0 operand 2.
- req1_valid, req1_ready, req1_ctr, req1_a, req1_b: same as requester 0, for requester 1.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester the response belongs to.
- rsp_result  out  WIDTH  operation result.
- rsp_err  out  1  mod by zero or mod timeout.
- alu_src1  out  WIDTH  operand 1 to the datapath.
- alu_src2  out  WIDTH  operand 2 to the datapath.
- alu_ctr  out  3  operation code to the datapath.
- alu_result  in  WIDTH  combinational ALU result.
- mod_start  out  1  one-cycle launch pulse to the mod unit.
- mod_done  in  1  mod unit finished.
- mod_result  in  WIDTH  mod unit result.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, last_grant=1, so req0 wins the first tie.
  - All outputs 0; wait counter 0.
- States: IDLE, ALU, MOD_START, MOD_WAIT, RESP.
- IDLE:
  - If only one reqX_valid is high, grant it.
  - If both are high, grant the one != last_grant.
  - reqX_ready is combinational: high only in IDLE for the granted requester. At most one ready is high per cycle.
  - On grant, register the operands, ctr and id, and update last_grant.
  - Next state:
    - ctr==3'b111 and b==0: go to RESP with result=0, err=1 (mod_start is never asserted).
    - ctr==3'b111 and b!=0: go to MOD_START.
    - otherwise: go to ALU.
- alu_src1, alu_src2 and alu_ctr are registered. They are stable from grant+1 until the return to IDLE.
- ALU: capture alu_result into rsp_result, err=0, go to RESP.
- MOD_START: mod_start=1 for exactly one cycle; clear the wait counter; go to MOD_WAIT.
- MOD_WAIT:
  - If mod_done=1: capture mod_result, err=0, go to RESP.
  - Else if counter==TIMEOUT-1: result=0, err=1, go to RESP.
  - Else increment the counter.
  - mod_done has priority over timeout in the same cycle.
- RESP:
  - rsp_valid=1; rsp_id, rsp_result and rsp_err are held stable until rsp_ready=1.
  - On the handshake, go to IDLE; rsp_valid drops the next cycle.
  - No new grant is made in the handshake cycle; the earliest next grant is the following cycle.
- mod_done is ignored in every state except MOD_WAIT.
- Latency, measured from the grant cycle (cycle 0):
  - ALU op: rsp_valid at cycle 2.
  - Mod op: mod_start at cycle 1; rsp_valid one cycle after mod_done is sampled.
  - Mod by zero: rsp_valid at cycle 1.
- Fairness: back-to-back contention alternates grants 0,1,0,1.
- Reset asserted mid-operation: returns immediately to the reset state. Any in-flight response is dropped. mod_start deasserts asynchronously.

Optional Feature:
- Macro: ALU_ARB_PERF_CNT_EN.
- When defined:
  - Adds output port op_count (16 bits): responses completed via the rsp handshake, saturating at 16'hFFFF.
  - Adds output port timeout_count (8 bits): MOD_WAIT timeouts, saturating at 8'hFF.
  - Both reset to 0.
- When undefined: neither port nor the counter logic exists; all other behaviour is identical.

Test Plan:
- req0 ctr=3'b010, a=5, b=7, rsp_ready=1 -> req0_ready at cycle 0; rsp_valid at cycle 2 with rsp_id=0, rsp_result=alu_result (12 from a model adder), rsp_err=0.
- Both valid, ALU ops, held for 4 operations -> grants in order 0,1,0,1; each rsp_id matches its grant.
- req1 ctr=3'b111, a=17, b=5; model asserts mod_done=1 with result 2 after 10 cycles -> one mod_start pulse at cycle 1; rsp_result=2, rsp_err=0, rsp_id=1.
- Mod with b=0 -> mod_start never asserted; rsp_valid at cycle 1 with result=0, err=1.
- Mod where mod_done never arrives, TIMEOUT=64 -> err=1, result=0 after 64 MOD_WAIT cycles; a spurious mod_done 5 cycles later in IDLE is ignored (no response).
- rsp_ready held 0 for 6 cycles in RESP, then reset pulsed low mid-operation -> outputs are stable while stalled; after reset, all outputs=0, busy=0, and the next tie is granted to req0.
